// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: IFU and LSU request/response channels plus the shared memory port.
// Handshake: a request transfers in a cycle where valid and ready are both high; valid stays up with stable fields until then, and respValid is a single-cycle pulse with no ready.
interface mem_arbiter_if;
  logic        ifu_reqValid;
  logic        ifu_reqReady;
  logic [31:0] ifu_raddr;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;
  logic        ifu_err;

  logic        lsu_reqValid;
  logic        lsu_reqReady;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;
  logic        lsu_err;

  logic        mem_reqValid;
  logic        mem_reqReady;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_respValid;
  logic [31:0] mem_rdata;

  logic [1:0]  dbg_state;

  modport slave (
    input  ifu_reqValid, ifu_raddr,
    input  lsu_reqValid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  mem_reqReady, mem_respValid, mem_rdata,
    output ifu_reqReady, ifu_respValid, ifu_rdata, ifu_err,
    output lsu_reqReady, lsu_respValid, lsu_rdata, lsu_err,
    output mem_reqValid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output dbg_state
  );

  modport master (
    output ifu_reqValid, ifu_raddr,
    output lsu_reqValid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output mem_reqReady, mem_respValid, mem_rdata,
    input  ifu_reqReady, ifu_respValid, ifu_rdata, ifu_err,
    input  lsu_reqReady, lsu_respValid, lsu_rdata, lsu_err,
    input  mem_reqValid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  dbg_state
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU and LSU: one latched transaction at a time,
// response routed to its owner, and a watchdog that turns a lost response into an error pulse.
module mem_arbiter #(
  parameter int ARB_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t        state;
  logic          owner;       // 0 = IFU, 1 = LSU
  logic          last_grant;
  logic [CW-1:0] cnt;

  logic          any_req;
  logic          grant_lsu;
  logic          grant_ifu;
  logic          timeout_hit;
  logic          cap_en;
  logic          cap_err;
  logic [31:0]   cap_data;

  always_comb begin
    any_req     = bus.ifu_reqValid | bus.lsu_reqValid;
    // Round-robin gives a tie to whoever was not granted last; fixed mode always favours LSU.
    grant_lsu   = bus.lsu_reqValid & (~bus.ifu_reqValid | (ARB_MODE == 0) | ~last_grant);
    grant_ifu   = bus.ifu_reqValid & ~grant_lsu;
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
    cap_en      = ((state == REQ) & bus.mem_reqReady & bus.mem_respValid) |
                  ((state == WAIT) & (bus.mem_respValid | timeout_hit));
    cap_err     = ~bus.mem_respValid;
    cap_data    = bus.mem_respValid ? bus.mem_rdata : 32'h0;
  end

  assign bus.ifu_reqReady = ~rst & (state == IDLE) & grant_ifu;
  assign bus.lsu_reqReady = ~rst & (state == IDLE) & grant_lsu;
  assign bus.dbg_state    = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      owner             <= 1'b0;
      last_grant        <= 1'b1;
      cnt               <= '0;
      bus.mem_reqValid  <= 1'b0;
      bus.mem_addr      <= 32'h0;
      bus.mem_wen       <= 1'b0;
      bus.mem_wdata     <= 32'h0;
      bus.mem_wmask     <= 4'h0;
      bus.ifu_respValid <= 1'b0;
      bus.ifu_rdata     <= 32'h0;
      bus.ifu_err       <= 1'b0;
      bus.lsu_respValid <= 1'b0;
      bus.lsu_rdata     <= 32'h0;
      bus.lsu_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner            <= grant_lsu;
            last_grant       <= grant_lsu;
            bus.mem_reqValid <= 1'b1;
            bus.mem_addr     <= grant_lsu ? bus.lsu_addr : bus.ifu_raddr;
            bus.mem_wen      <= grant_lsu & bus.lsu_wen;
            bus.mem_wdata    <= grant_lsu ? bus.lsu_wdata : 32'h0;
            bus.mem_wmask    <= grant_lsu ? bus.lsu_wmask : 4'h0;
            state            <= REQ;
          end
        end
        REQ: begin
          if (bus.mem_reqReady) begin
            bus.mem_reqValid <= 1'b0;
            cnt              <= '0;
            state            <= cap_en ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
          if (cap_en) state <= RESP;
        end
        RESP: begin
          bus.ifu_respValid <= 1'b0;
          bus.ifu_rdata     <= 32'h0;
          bus.ifu_err       <= 1'b0;
          bus.lsu_respValid <= 1'b0;
          bus.lsu_rdata     <= 32'h0;
          bus.lsu_err       <= 1'b0;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Response registers load on the way into RESP so the pulse is exactly one cycle.
      if (cap_en) begin
        bus.ifu_respValid <= ~owner;
        bus.ifu_rdata     <= owner ? 32'h0 : cap_data;
        bus.ifu_err       <= ~owner & cap_err;
        bus.lsu_respValid <= owner;
        bus.lsu_rdata     <= owner ? cap_data : 32'h0;
        bus.lsu_err       <= owner & cap_err;
      end
    end
  end
endmodule
